mem_arbiter: RTL and testbench

Two-port to one-port cacheline memory arbiter between the I-cache and D-cache miss ports and the single physical memory port. It serializes cacheline reads and writebacks and returns a one-cycle response to the requesting cache. The caches' hit responses feed `imem_resp`/`dmem_resp` to the hazard unit, so this block decides when a missing fetch or load/store unstalls the pipeline.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates I-cache and D-cache line misses onto one physical memory port (optional round-robin: MEM_ARBITER_RR_EN).
// Latency : grant edge -> command next cycle; pmem_resp in cycle N -> *_pmem_resp in N+1, IDLE in N+2.
// Backpr. : requests are level-held; a requester simply waits (stalls) until its one-cycle resp pulse.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  // I-cache miss port
  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_address,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  // D-cache miss port
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  // physical memory port
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           grant_i;
  logic           grant_d;
  logic           i_pend;
  logic           d_pend;
  logic           busy;
  logic           cmd_write;
  logic [31:0]    cmd_addr;
  logic [255:0]   cmd_wdata;
  logic [255:0]   line_q;
  // 1 = last completed transaction served D, 0 = served I
  logic           last_grant_d;

  assign i_pend = i_pmem_read;
  assign d_pend = d_pmem_read | d_pmem_write;
  assign busy   = (state == I_BUSY) || (state == D_BUSY);

  // Next-state and grant decode; grants only exist in IDLE.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend && d_pend) begin
`ifdef MEM_ARBITER_RR_EN
          // Tie goes to the side that was not served last.
          grant_d = ~last_grant_d;
          grant_i = last_grant_d;
`else
          // The MEM-stage access is older than the fetch, so D wins ties.
          grant_d = 1'b1;
`endif
        end else if (d_pend) begin
          grant_d = 1'b1;
        end else if (i_pend) begin
          grant_i = 1'b1;
        end
        if (grant_d)      state_nxt = D_BUSY;
        else if (grant_i) state_nxt = I_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latch the winning request on the grant edge; write beats read on the D side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_write <= 1'b0;
      cmd_addr  <= 32'd0;
      cmd_wdata <= 256'd0;
    end else if (grant_d) begin
      cmd_write <= d_pmem_write;
      cmd_addr  <= d_pmem_address;
      cmd_wdata <= d_pmem_wdata;
    end else if (grant_i) begin
      cmd_write <= 1'b0;
      cmd_addr  <= i_pmem_address;
    end
  end

  // Capture returned line and the served side when memory completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q       <= 256'd0;
      last_grant_d <= 1'b1;
    end else if (busy && pmem_resp) begin
      line_q       <= pmem_rdata;
      last_grant_d <= (state == D_BUSY);
    end
  end

  // All outputs come from state or registers only.
  assign pmem_read    = busy & ~cmd_write;
  assign pmem_write   = busy & cmd_write;
  assign pmem_address = cmd_addr;
  assign pmem_wdata   = cmd_wdata;
  assign i_pmem_resp  = (state == DONE) & ~last_grant_d;
  assign d_pmem_resp  = (state == DONE) & last_grant_d;
  assign i_pmem_rdata = line_q;
  assign d_pmem_rdata = line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed bench for mem_arbiter with a latency-programmable memory model and a scoreboard.
// Latency : memory answers mem_lat cycles after a command appears.
// Backpr. : requester tasks hold requests until their resp pulse, then drop them on the next edge.
module tb_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  logic         mem_resp;
  logic         spur;
  int           mem_cnt;
  int           mem_lat;
  int           compared;
  int           mismatched;

  typedef struct packed {
    logic         wr;
    logic         chk_wdata;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic         side_d;
    logic         chk_data;
    logic [255:0] data;
  } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];
  logic  prev_cmd;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int j = 0; j < 8; j++) l[j*32 +: 32] = a ^ (32'h1000_0000 * j) ^ 32'hC0DE_0000;
    return l;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: event got 1 expected 0", nm);
  endtask

  // Memory model: responds mem_lat cycles after a command shows up.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_resp   <= 1'b0;
      mem_cnt    <= 0;
      pmem_rdata <= 256'd0;
    end else if ((pmem_read || pmem_write) && !mem_resp) begin
      if (mem_cnt == mem_lat - 1) begin
        mem_resp   <= 1'b1;
        mem_cnt    <= 0;
        pmem_rdata <= mem_line(pmem_address);
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_resp <= 1'b0;
    end
  end

  assign pmem_resp = mem_resp | spur;

  // Monitor: compares each new memory command and each resp pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_cmd = 1'b0;
    end else begin
      cmd_t  ec;
      resp_t er;
      if (pmem_read && pmem_write) fail("cmd_both_high");
      if ((pmem_read || pmem_write) && !prev_cmd) begin
        if (cmd_q.size() == 0) fail("cmd_unexpected");
        else begin
          ec = cmd_q.pop_front();
          chk("cmd_op_write", pmem_write, ec.wr);
          chk("cmd_addr", pmem_address, ec.addr);
          if (ec.chk_wdata) chk("cmd_wdata", pmem_wdata, ec.wdata);
        end
      end
      prev_cmd = pmem_read | pmem_write;
      if (i_pmem_resp && d_pmem_resp) fail("resp_both_high");
      if (i_pmem_resp || d_pmem_resp) begin
        if (resp_q.size() == 0) fail("resp_unexpected");
        else begin
          er = resp_q.pop_front();
          chk("resp_side_d", d_pmem_resp, er.side_d);
          if (er.chk_data) chk("resp_data", d_pmem_resp ? d_pmem_rdata : i_pmem_rdata, er.data);
        end
      end
    end
  end

  task automatic exp_cmd(input logic wr, input logic [31:0] a, input logic cw, input logic [255:0] wd);
    cmd_t c;
    c.wr = wr; c.addr = a; c.chk_wdata = cw; c.wdata = wd;
    cmd_q.push_back(c);
  endtask

  task automatic exp_resp(input logic sd, input logic cd, input logic [255:0] d);
    resp_t r;
    r.side_d = sd; r.chk_data = cd; r.data = d;
    resp_q.push_back(r);
  endtask

  task automatic i_req(input logic [31:0] a, input int exp_lat);
    int n;
    bit got;
    n = 0;
    got = 0;
    i_pmem_address = a;
    i_pmem_read = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (i_pmem_resp) begin
        got = 1;
        break;
      end
      n++;
    end
    if (!got) fail("i_timeout");
    else if (exp_lat >= 0) chk("i_latency", n, exp_lat);
    @(posedge clk);
    #1 i_pmem_read = 1'b0;
  endtask

  task automatic wait_d_resp(input string nm);
    bit got;
    got = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (d_pmem_resp) begin
        got = 1;
        break;
      end
    end
    if (!got) fail(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic d_req(input logic [31:0] a, input logic wr, input logic [255:0] wd);
    d_pmem_address = a;
    d_pmem_wdata   = wd;
    d_pmem_write   = wr;
    d_pmem_read    = ~wr;
    wait_d_resp("d_timeout");
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_pmem_read"}, pmem_read, 0);
    chk({pfx, "_pmem_write"}, pmem_write, 0);
    chk({pfx, "_i_resp"}, i_pmem_resp, 0);
    chk({pfx, "_d_resp"}, d_pmem_resp, 0);
    chk({pfx, "_pmem_address"}, pmem_address, 0);
    chk({pfx, "_pmem_wdata"}, pmem_wdata, 0);
    chk({pfx, "_i_rdata"}, i_pmem_rdata, 0);
    chk({pfx, "_d_rdata"}, d_pmem_rdata, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: sim time got limit expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic [255:0] wd;
    logic [31:0]  ia;
    logic [31:0]  da;
    bit           seen;
    compared = 0; mismatched = 0;
    rst = 1'b1; spur = 1'b0; mem_lat = 4;
    i_pmem_read = 0; i_pmem_address = 0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = 0; d_pmem_wdata = 0;
    prev_cmd = 0;
    #12;
    chk_outputs_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single I read, latency 4: resp pulse in cycle 6.
    exp_cmd(1'b0, 32'h60, 1'b0, 256'd0);
    exp_resp(1'b0, 1'b1, mem_line(32'h60));
    i_req(32'h60, 6);
    @(posedge clk); #1;

    // D writeback.
    wd = {8{32'hDEADBEEF}};
    exp_cmd(1'b1, 32'h1000, 1'b1, wd);
    exp_resp(1'b1, 1'b0, 256'd0);
    d_req(32'h1000, 1'b1, wd);
    @(posedge clk); #1;

    // Two back-to-back rounds of simultaneous I and D reads.
    mem_lat = 2;
    for (int r = 0; r < 2; r++) begin
      ia = 32'h200 + 32'h20 * r;
      da = 32'h3000 + 32'h20 * r;
`ifdef MEM_ARBITER_RR_EN
      exp_cmd(1'b0, ia, 1'b0, 256'd0); exp_resp(1'b0, 1'b1, mem_line(ia));
      exp_cmd(1'b0, da, 1'b0, 256'd0); exp_resp(1'b1, 1'b1, mem_line(da));
`else
      exp_cmd(1'b0, da, 1'b0, 256'd0); exp_resp(1'b1, 1'b1, mem_line(da));
      exp_cmd(1'b0, ia, 1'b0, 256'd0); exp_resp(1'b0, 1'b1, mem_line(ia));
`endif
      fork
        i_req(ia, -1);
        d_req(da, 1'b0, 256'd0);
      join
    end
    @(posedge clk); #1;

    // D read and write together: write first, then the read.
    wd = {8{32'h0BAD_F00D}};
    exp_cmd(1'b1, 32'h4000, 1'b1, wd); exp_resp(1'b1, 1'b0, 256'd0);
    exp_cmd(1'b0, 32'h4000, 1'b0, 256'd0); exp_resp(1'b1, 1'b1, mem_line(32'h4000));
    d_pmem_address = 32'h4000; d_pmem_wdata = wd;
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    wait_d_resp("drw_timeout_w");
    d_pmem_write = 1'b0;
    wait_d_resp("drw_timeout_r");
    d_pmem_read = 1'b0;
    @(posedge clk); #1;

    // Reset two cycles into a BUSY, then the held request completes from scratch.
    mem_lat = 10;
    exp_cmd(1'b0, 32'h80, 1'b0, 256'd0);
    fork
      i_req(32'h80, -1);
      begin
        seen = 0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (pmem_read) begin
            seen = 1;
            break;
          end
        end
        if (!seen) fail("rst_test_no_cmd");
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_outputs_zero("midrst");
        exp_cmd(1'b0, 32'h80, 1'b0, 256'd0);
        exp_resp(1'b0, 1'b1, mem_line(32'h80));
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
      end
    join
    @(posedge clk); #1;

    // Spurious pmem_resp in IDLE is ignored.
    mem_lat = 2;
    spur = 1'b1;
    @(posedge clk);
    #1 spur = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("spur_cmd", pmem_read | pmem_write, 0);
      chk("spur_resp", i_pmem_resp | d_pmem_resp, 0);
    end
    @(posedge clk); #1;
    exp_cmd(1'b0, 32'h20, 1'b0, 256'd0);
    exp_resp(1'b0, 1'b1, mem_line(32'h20));
    i_req(32'h20, 4);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
